// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode constants and scheduler state type shared across the codebase.
package alu_pkg;

    localparam logic [7:0] ADD          = 8'h00;
    localparam logic [7:0] SUBTRACT     = 8'h01;
    localparam logic [7:0] MULTIPLY     = 8'h02;
    localparam logic [7:0] EQUALS       = 8'h03;
    localparam logic [7:0] GREATER_THAN = 8'h04;
    localparam logic [7:0] OPCODE_MAX   = 8'h04;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/alu.sv
// alu: 8-bit signed wrapping ALU; opcodes above OPCODE_MAX flag an error and yield 0.
module alu
    import alu_pkg::*;
(
    input  logic              reset_in,
    input  logic              enable_in,
    input  logic        [7:0] opcode_in,
    input  logic signed [7:0] a_in,
    input  logic signed [7:0] b_in,
    output logic signed [7:0] result_out,
    output logic              err_out
);

    logic on;

    always_comb begin
        on = reset_in && enable_in;
        err_out = on && (opcode_in > OPCODE_MAX);
        result_out = (!on || err_out)        ? 8'sd0 :
                     (opcode_in == ADD)      ? a_in + b_in :
                     (opcode_in == SUBTRACT) ? a_in - b_in :
                     (opcode_in == MULTIPLY) ? 8'(a_in * b_in) :
                     (opcode_in == EQUALS)   ? {7'd0, a_in == b_in} :
                                               {7'd0, a_in > b_in};
    end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational one-hot arbiter searching from ptr_i+1 upward, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          advance_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        grant_o = '0;
        idx_o = '0;
        // Walk from the lowest priority slot up so the last hit is the winner.
        for (int k = N; k >= 1; k--) begin
            int j;
            j = (int'(ptr_i) + k) % N;
            if (advance_i && req_i[j]) begin
                grant_o = '0;
                grant_o[j] = 1'b1;
                idx_o = IW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: shares one ALU among NUM_REQ requesters behind a one-entry result register.
// Define ALU_SCHED_RR_EN for round-robin arbitration; otherwise lowest index wins.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                       clock_in,
    input  logic                       reset_in,
    input  logic [NUM_REQ-1:0]         req_valid_in,
    input  logic [NUM_REQ*8-1:0]       req_opcode_in,
    input  logic [NUM_REQ*8-1:0]       req_a_in,
    input  logic [NUM_REQ*8-1:0]       req_b_in,
    output logic [NUM_REQ-1:0]         req_ready_out,
    output logic                       result_valid_out,
    output logic [7:0]                 result_out,
    output logic [$clog2(NUM_REQ)-1:0] result_id_out,
    output logic                       result_err_out,
    input  logic                       result_ready_in,
    output logic [CNT_W-1:0]           ops_done_out
);

    localparam int IW = $clog2(NUM_REQ);

    sched_state_t   state_q, state_d;
    logic [7:0]     result_q, result_d;
    logic [IW-1:0]  id_q, id_d;
    logic           err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IW-1:0]  ptr, grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic           advance, fire, accept;
    logic [7:0]     alu_res;
    logic           alu_err;

    assign advance = reset_in && (state_q == EMPTY || result_ready_in);
    assign fire = |grant;
    assign accept = (state_q == FULL) && result_ready_in;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req_i    (req_valid_in),
        .ptr_i    (ptr),
        .advance_i(advance),
        .grant_o  (grant),
        .idx_o    (grant_idx)
    );

    alu u_alu (
        .reset_in  (1'b1),
        .enable_in (1'b1),
        .opcode_in (req_opcode_in[int'(grant_idx)*8 +: 8]),
        .a_in      (req_a_in[int'(grant_idx)*8 +: 8]),
        .b_in      (req_b_in[int'(grant_idx)*8 +: 8]),
        .result_out(alu_res),
        .err_out   (alu_err)
    );

`ifdef ALU_SCHED_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;

    assign ptr_d = fire ? grant_idx : ptr_q;
    assign ptr = ptr_q;

    always_ff @(posedge clock_in) begin
        if (!reset_in) ptr_q <= IW'(NUM_REQ - 1);
        else ptr_q <= ptr_d;
    end
`else
    assign ptr = IW'(NUM_REQ - 1);
`endif

    always_comb begin
        state_d = fire ? FULL : (accept ? EMPTY : state_q);
        result_d = fire ? alu_res : result_q;
        id_d = fire ? grant_idx : id_q;
        err_d = fire ? alu_err : err_q;
        cnt_d = cnt_q + CNT_W'(accept);
    end

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            state_q <= EMPTY;
            result_q <= '0;
            id_q <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            result_q <= result_d;
            id_q <= id_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign req_ready_out = grant;
    assign result_valid_out = (state_q == FULL);
    assign result_out = result_q;
    assign result_id_out = id_q;
    assign result_err_out = err_q;
    assign ops_done_out = cnt_q;

endmodule
